bist_response_analyzer: RTL and testbench

- Receiving end of the BIST test path: compacts scan-out response beats from the circuit under test into a MISR signature.
- After a fixed beat count, compares the signature with a golden value and reports the verdict as pass_nfail and bist_end.
- Sits beside the BIST pattern controller. Its start comes from the controller's bist_start; its response input comes from the scan chain test_out.

---
 rtl/bist_response_analyzer.sv | 120 ++++++++++++
 tb/tb_bist_response_analyzer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - MISR response compactor with golden-signature verdict
module bist_response_analyzer #(
    parameter int               WIDTH     = 2,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] POLY      = 16'h002D,
    parameter logic [SIG_W-1:0] SEED      = '0,
    parameter logic [SIG_W-1:0] GOLDEN    = '0,
    parameter int               NUM_BEATS = 32,
    parameter int               TIMEOUT   = 64,
    localparam int              CNT_W     = $clog2(NUM_BEATS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             bist_end,
    output logic             pass_nfail,
    output logic             timeout,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] beat_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SIG_W-1:0]  sig_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              busy_d, end_d, pass_d, to_d;
    logic [SIG_W-1:0]  misr_next;

    // Galois MISR step: shift, fold the carried-out bit back through POLY, absorb the beat
    assign misr_next = (signature << 1) ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp_data);

    // State and datapath registers; every output comes straight from a flop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            signature  <= SEED;
            beat_count <= '0;
            idle_q     <= '0;
            busy       <= 1'b0;
            bist_end   <= 1'b0;
            pass_nfail <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            signature  <= sig_d;
            beat_count <= cnt_d;
            idle_q     <= idle_d;
            busy       <= busy_d;
            bist_end   <= end_d;
            pass_nfail <= pass_d;
            timeout    <= to_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition says otherwise
    always_comb begin
        state_d = state_q;
        sig_d   = signature;
        cnt_d   = beat_count;
        idle_d  = idle_q;
        busy_d  = busy;
        end_d   = bist_end;
        pass_d  = pass_nfail;
        to_d    = timeout;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE restarts exactly like IDLE so the controller can chain runs
                if (start) begin
                    state_d = S_COLLECT;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    idle_d  = '0;
                    to_d    = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    end_d   = 1'b0;
                end
            end
            S_COLLECT: begin
                // A beat on the threshold edge wins over the timeout
                if (resp_valid) begin
                    sig_d  = misr_next;
                    cnt_d  = beat_count + 1'b1;
                    idle_d = '0;
                    if (beat_count == CNT_W'(NUM_BEATS - 1))
                        state_d = S_COMPARE;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_d = S_DONE;
                        to_d    = 1'b1;
                        pass_d  = 1'b0;
                        busy_d  = 1'b0;
                        end_d   = 1'b1;
                    end
                end
            end
            S_COMPARE: begin
                pass_d  = (signature == GOLDEN);
                state_d = S_DONE;
                busy_d  = 1'b0;
                end_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       resp_valid = 1'b0;
    logic [1:0] resp_data = 2'b00;

    logic       busy_p, end_p, pass_p, to_p;
    logic [3:0] sig_p;
    logic [2:0] cnt_p;
    logic       busy_f, end_f, pass_f, to_f;
    logic [3:0] sig_f;
    logic [2:0] cnt_f;

    int checks = 0;
    int errors = 0;

    int m_sig;
    int m_cnt;

    always #5 clock = ~clock;

    bist_response_analyzer #(
        .WIDTH(2), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h6),
        .NUM_BEATS(4), .TIMEOUT(8)
    ) dut_p (
        .clock(clock), .reset(reset), .start(start),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy_p), .bist_end(end_p), .pass_nfail(pass_p), .timeout(to_p),
        .signature(sig_p), .beat_count(cnt_p)
    );

    bist_response_analyzer #(
        .WIDTH(2), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h7),
        .NUM_BEATS(4), .TIMEOUT(8)
    ) dut_f (
        .clock(clock), .reset(reset), .start(start),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy_f), .bist_end(end_f), .pass_nfail(pass_f), .timeout(to_f),
        .signature(sig_f), .beat_count(cnt_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference signature: the 4-bit register treated as a polynomial over GF(2),
    // multiplied by x and reduced by x^4 + x + 1, then the beat added in.
    function automatic int model_misr(input int s, input int d);
        int t;
        t = s * 2;
        if (t >= 16) t = (t - 16) ^ 3;
        return t ^ d;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy_p"}, busy_p, 0);
        chk({tag, "_end_p"}, end_p, 0);
        chk({tag, "_pass_p"}, pass_p, 0);
        chk({tag, "_to_p"}, to_p, 0);
        chk({tag, "_sig_p"}, sig_p, 0);
        chk({tag, "_cnt_p"}, cnt_p, 0);
        chk({tag, "_sig_f"}, sig_f, 0);
        chk({tag, "_busy_f"}, busy_f, 0);
    endtask

    task automatic start_run(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        m_sig = 0;
        m_cnt = 0;
        chk({tag, "_start_busy"}, busy_p, 1);
        chk({tag, "_start_end"}, end_p, 0);
        chk({tag, "_start_sig"}, sig_p, 0);
        chk({tag, "_start_cnt"}, cnt_p, 0);
    endtask

    task automatic send_beat(input string tag, input logic [1:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        step();
        resp_valid = 1'b0;
        resp_data  = 2'($urandom);
        m_sig = model_misr(m_sig, int'(d));
        m_cnt++;
        chk({tag, "_sig_p"}, sig_p, m_sig);
        chk({tag, "_sig_f"}, sig_f, m_sig);
        chk({tag, "_cnt"}, cnt_p, m_cnt);
        chk({tag, "_busy"}, busy_p, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            resp_valid = 1'b0;
            resp_data  = 2'($urandom);
            step();
        end
    endtask

    // Called right after the final beat's edge: one COMPARE cycle, then DONE
    task automatic finish_run(input string tag);
        chk({tag, "_cmp_busy"}, busy_p, 1);
        chk({tag, "_cmp_end"}, end_p, 0);
        resp_valid = 1'b1;
        resp_data  = 2'($urandom);
        step();
        resp_valid = 1'b0;
        chk({tag, "_end_p"}, end_p, 1);
        chk({tag, "_end_f"}, end_f, 1);
        chk({tag, "_busy"}, busy_p, 0);
        chk({tag, "_pass_p"}, pass_p, (m_sig == 6) ? 1 : 0);
        chk({tag, "_pass_f"}, pass_f, (m_sig == 7) ? 1 : 0);
        chk({tag, "_to"}, to_p, 0);
        chk({tag, "_sig"}, sig_p, m_sig);
        chk({tag, "_cnt"}, cnt_p, 4);
    endtask

    initial begin
        logic [1:0] dir_beats [4];
        logic [3:0] dir_sigs  [4];
        dir_beats = '{2'b01, 2'b10, 2'b11, 2'b00};
        dir_sigs  = '{4'h1, 4'h0, 4'h3, 4'h6};

        #1;
        chk_quiet("reset");
        #3 reset = 1'b1;
        step();
        chk_quiet("idle");

        // Directed clean pass on dut_p, fail on dut_f
        start_run("clean");
        for (int i = 0; i < 4; i++) begin
            send_beat("clean_beat", dir_beats[i]);
            chk("clean_dir_sig", sig_p, dir_sigs[i]);
        end
        finish_run("clean");
        chk("clean_pass_const", pass_p, 1);
        chk("fail_pass_const", pass_f, 0);

        // Beats offered in DONE must not disturb the held result
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp_data  = 2'($urandom);
            step();
        end
        resp_valid = 1'b0;
        chk("done_hold_sig", sig_p, 6);
        chk("done_hold_end", end_p, 1);
        chk("done_hold_cnt", cnt_p, 4);
        chk("done_hold_pass", pass_p, 1);

        // Gapped input, restarted directly from DONE
        start_run("gap");
        send_beat("gap_b0", 2'b01);
        send_beat("gap_b1", 2'b10);
        idle_cycles(3);
        chk("gap_idle_sig", sig_p, 0);
        chk("gap_idle_cnt", cnt_p, 2);
        send_beat("gap_b2", 2'b11);
        send_beat("gap_b3", 2'b00);
        finish_run("gap");
        chk("gap_sig6", sig_p, 6);

        // start during COLLECT and during COMPARE is ignored
        start_run("ign");
        send_beat("ign_b0", 2'b01);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_start_cnt", cnt_p, 1);
        chk("ign_start_sig", sig_p, 1);
        chk("ign_start_busy", busy_p, 1);
        send_beat("ign_b1", 2'b10);
        send_beat("ign_b2", 2'b11);
        send_beat("ign_b3", 2'b00);
        start = 1'b1;
        finish_run("ign");
        start = 1'b0;
        chk("ign_cmp_start_sig", sig_p, 6);

        // Timeout: two beats then silence
        step();
        start_run("to");
        send_beat("to_b0", 2'($urandom));
        send_beat("to_b1", 2'($urandom));
        idle_cycles(7);
        chk("to_pre_busy", busy_p, 1);
        chk("to_pre_flag", to_p, 0);
        chk("to_pre_end", end_p, 0);
        idle_cycles(1);
        chk("to_flag", to_p, 1);
        chk("to_end", end_p, 1);
        chk("to_pass_p", pass_p, 0);
        chk("to_pass_f", pass_f, 0);
        chk("to_busy", busy_p, 0);
        chk("to_cnt", cnt_p, 2);
        chk("to_sig", sig_p, m_sig);

        // A beat on the threshold edge beats the timeout
        start_run("edge");
        idle_cycles(7);
        send_beat("edge_b0", 2'($urandom));
        chk("edge_no_to", to_p, 0);
        idle_cycles(7);
        chk("edge_still_busy", busy_p, 1);
        for (int i = 1; i < 4; i++) send_beat("edge_b", 2'($urandom));
        finish_run("edge");

        // Random runs with random gaps below the timeout
        for (int r = 0; r < 8; r++) begin
            start_run("rnd");
            for (int i = 0; i < 4; i++) begin
                idle_cycles(int'($urandom_range(0, 7)));
                send_beat("rnd_beat", 2'($urandom));
            end
            finish_run("rnd");
        end

        // Asynchronous reset mid-run
        start_run("rst");
        send_beat("rst_b0", 2'b01);
        send_beat("rst_b1", 2'b10);
        #2 reset = 1'b0;
        #1;
        chk_quiet("rst_async");
        @(negedge clock);
        reset = 1'b1;
        step();
        chk_quiet("rst_after");
        start_run("post");
        for (int i = 0; i < 4; i++) send_beat("post_beat", dir_beats[i]);
        finish_run("post");
        chk("post_pass", pass_p, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
